// File: rtl/hpc1_issue_sequencer.sv
// rtl/hpc1_issue_sequencer.sv - issue sequencer for a 3-share 8-bit HPC1 AND gadget with credit-based result FIFO.
// Define HPC1_SEQ_PRNG_EN to source gadget randomness from an internal LFSR instead of rnd_*.
module hpc1_issue_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_a,
  input  logic [23:0]      in_b,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [39:0]      rnd_data,
  output logic [7:0]       g_a0,
  output logic [7:0]       g_a1,
  output logic [7:0]       g_a2,
  output logic [7:0]       g_b0,
  output logic [7:0]       g_b1,
  output logic [7:0]       g_b2,
  output logic [7:0]       g_r0,
  output logic [7:0]       g_r1,
  output logic [7:0]       g_p01,
  output logic [7:0]       g_p02,
  output logic [7:0]       g_p12,
  input  logic [7:0]       g_c0,
  input  logic [7:0]       g_c1,
  input  logic [7:0]       g_c2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_c,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t           state_q;
  logic [1:0]       pipe_q;
  logic [1:0]       inflight_q;
  logic [1:0]       inflight_d;
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;
  logic [23:0]      mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [PW:0]      fifo_count;
  logic [PW:0]      free_slots;
  logic [39:0]      rnd_bits;
  logic             rand_avail;
  logic             fire;
  logic             capture;
  logic             push;
  logic             pop;

`ifdef HPC1_SEQ_PRNG_EN
  logic [39:0] lfsr_q;
  logic        unused_rnd;

  assign unused_rnd = ^{rnd_valid, rnd_data};
  assign rnd_bits   = lfsr_q;
  assign rand_avail = 1'b1;
  assign rnd_ready  = 1'b0;

  // Fibonacci LFSR x^40+x^38+x^21+x^19+1, stepped once per issue so no word is reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 40'hA5_C3_96_0F_1E;
    end else if (fire) begin
      lfsr_q <= {lfsr_q[38:0], lfsr_q[39] ^ lfsr_q[37] ^ lfsr_q[20] ^ lfsr_q[18]};
    end
  end
`else
  assign rnd_bits   = rnd_data;
  assign rand_avail = rnd_valid;
  assign rnd_ready  = fire;
`endif

  assign fifo_count = wr_q - rd_q;
  assign free_slots = (PW+1)'(DEPTH) - fifo_count;

  // Credit rule: only issue while every in-flight result already owns a free FIFO slot.
  assign in_ready = ~rst & ~flush & (state_q != FLUSH) & rand_avail &
                    (free_slots > (PW+1)'(inflight_q));
  assign fire     = in_valid & in_ready;
  assign capture  = pipe_q[1];
  assign push     = capture & (state_q != FLUSH);

  assign out_valid = ~flush & (state_q != FLUSH) & (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_c     = out_valid ? mem_q[rd_q[PW-1:0]] : 24'h0;

  assign {g_a2, g_a1, g_a0}                 = fire ? in_a : 24'h0;
  assign {g_b2, g_b1, g_b0}                 = fire ? in_b : 24'h0;
  assign {g_p12, g_p02, g_p01, g_r1, g_r0}  = fire ? rnd_bits : 40'h0;

  assign busy     = (state_q != IDLE);
  assign op_count = cnt_q;

  always_comb begin
    inflight_d = inflight_q;
    if (fire && !capture) begin
      inflight_d = inflight_q + 2'd1;
    end else if (!fire && capture) begin
      inflight_d = inflight_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pipe_q     <= '0;
      inflight_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      pipe_q     <= {pipe_q[0], fire};
      inflight_q <= inflight_d;
      if (fire && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (flush) begin
        state_q <= FLUSH;
      end else begin
        case (state_q)
          IDLE: begin
            if (fire) state_q <= ACTIVE;
          end
          ACTIVE: begin
            if (!fire && inflight_q == 2'd0 && fifo_count == '0) state_q <= IDLE;
          end
          FLUSH: begin
            // Late captures were already dropped; discard whatever was queued before the flush.
            if (inflight_q == 2'd0) begin
              wr_q    <= '0;
              rd_q    <= '0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[PW-1:0]] <= {g_c2, g_c1, g_c0};
    end
  end

endmodule
